// File: rtl/instr_mem_responder.sv
// Instruction-memory fetch responder: LATENCY-cycle read pipeline feeding an in-order response FIFO.
// Credits cap outstanding requests at FIFO_DEPTH so the FIFO never overflows; flush drops everything in flight.
module instr_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        flush,
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_instr,
  output logic [31:0] rsp_addr,
  output logic        rsp_fault
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        fault;
  } rsp_t;

  logic [31:0]       mem [DEPTH_WORDS];
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     fcnt;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [LATENCY-1:0] pv;
  rsp_t              pd [LATENCY];
  rsp_t              fd [FIFO_DEPTH];
  rsp_t              new_ent;
  logic              accept;
  logic              pop;
  logic              push;
  logic              req_fault;
  logic              unused_wr_bits;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // req_ready depends only on registered credit state and flush, never on rsp_ready.
  assign req_ready = (cnt < CW'(FIFO_DEPTH)) && !flush;
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (fcnt != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign push      = pv[LATENCY-1];

  assign req_fault = (req_addr[1:0] != 2'b00) ||
                     ({2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS));

  always_comb begin
    new_ent       = '0;
    new_ent.addr  = req_addr;
    new_ent.fault = req_fault;
    new_ent.instr = req_fault ? NOP : mem[req_addr[AW+1:2]];
  end

  // The array has no reset; the nonblocking write keeps same-cycle reads on the old word.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr[AW+1:2]] <= wr_data;
    end
  end

  assign unused_wr_bits = ^{wr_addr[31:AW+2], wr_addr[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(accept) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv <= '0;
    end else if (flush) begin
      pv <= '0;
    end else begin
      pv[0] <= accept;
      for (int i = 1; i < int'(LATENCY); i++) begin
        pv[i] <= pv[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    pd[0] <= new_ent;
    for (int i = 1; i < int'(LATENCY); i++) begin
      pd[i] <= pd[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fcnt   <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fcnt   <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      fcnt <= fcnt + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fd[wr_ptr] <= pd[LATENCY-1];
    end
  end

  // Outputs read as zero whenever the FIFO is empty, including under reset.
  assign rsp_instr = rsp_valid ? fd[rd_ptr].instr : '0;
  assign rsp_addr  = rsp_valid ? fd[rd_ptr].addr  : '0;
  assign rsp_fault = rsp_valid ? fd[rd_ptr].fault : 1'b0;

endmodule
